// File: rtl/gpr_pkg.sv
// Shared constants and types for the multi-port general-purpose register file.
package gpr_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PC_W       = 32;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } trace_rec_t;

endpackage

// File: rtl/gpr_file_mp_if.sv
// Decode/writeback-facing bundle of the register file: reads, writes, issue and write trace.
interface gpr_file_mp_if
  import gpr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [1:0]               wr_en;
  logic [2*ADDR_W-1:0]      wr_addr;
  logic [2*DATA_W-1:0]      wr_data;
  logic [2*PC_W-1:0]        wr_pc;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [1:0]               trace_valid;
  logic [2*ADDR_W-1:0]      trace_addr;
  logic [2*DATA_W-1:0]      trace_data;
  logic [2*PC_W-1:0]        trace_pc;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
    input  rd_data, rd_busy, trace_valid, trace_addr, trace_data, trace_pc
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
    output rd_data, rd_busy, trace_valid, trace_addr, trace_data, trace_pc
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: set by issue, cleared by effective writes, with lookups for each read port.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [1:0]               clr_en,
  input  logic [2*ADDR_W-1:0]      clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        busy_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Clears are applied before the set so a same-cycle issue (younger) wins.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < 2; i++) begin
      if (clr_en[i]) busy_next[clr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en && (iss_addr != ZERO_ADDR)) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  always_comb begin
    busy_out = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      busy_out[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: NUM_RD combinational read ports with optional write bypass,
// two prioritised write lanes (lane 1 younger), busy scoreboard and a registered write trace.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input logic          clk,
  input logic          reset,
  gpr_file_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [1:0]        wr_eff;
  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wa[i]     = bus.wr_addr[i*ADDR_W +: ADDR_W];
      wd[i]     = bus.wr_data[i*DATA_W +: DATA_W];
      wr_eff[i] = bus.wr_en[i] && (wa[i] != ZERO_ADDR);
    end
  end

  // Lane 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      if (wr_eff[0]) regs[wa[0]] <= wd[0];
      if (wr_eff[1]) regs[wa[1]] <= wd[1];
    end
  end

  always_comb begin
    bus.rd_data = '0;
    ra = '0;
    rv = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rv = regs[ra];
      if (BYPASS) begin
        if (wr_eff[0] && (wa[0] == ra)) rv = wd[0];
        if (wr_eff[1] && (wa[1] == ra)) rv = wd[1];
      end
      bus.rd_data[k*DATA_W +: DATA_W] = rv;
    end
  end

  // Idle trace lanes are forced to zero rather than holding stale values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.trace_valid <= '0;
      bus.trace_addr  <= '0;
      bus.trace_data  <= '0;
      bus.trace_pc    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bus.trace_valid[i]                  <= wr_eff[i];
        bus.trace_addr[i*ADDR_W +: ADDR_W]  <= wr_eff[i] ? wa[i] : '0;
        bus.trace_data[i*DATA_W +: DATA_W]  <= wr_eff[i] ? wd[i] : '0;
        bus.trace_pc[i*PC_W +: PC_W]        <= wr_eff[i] ? bus.wr_pc[i*PC_W +: PC_W] : '0;
      end
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .clr_en   (wr_eff),
    .clr_addr (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .busy_out (bus.rd_busy)
  );

endmodule
